// File: rtl/antisat_seq_lock.sv
// antisat_seq_lock: sequential Anti-SAT lock block.
// - Loads a 2N-bit key serially: K1 in key bits 0..N-1, K2 in key bits N..2N-1.
// - Computes the Anti-SAT flip bit over x_in.
// - Corrupts the protected target nets through a one-stage registered XOR.
// - Counts flip events with a saturating counter.
module antisat_seq_lock #(
    parameter int N       = 16,
    parameter int TGT_W   = 1,
    parameter int CNT_W   = 16,
    parameter int LOCKOUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_bit,
    input  logic             key_valid,
    input  logic             key_start,
    input  logic             key_clear,
    input  logic [N-1:0]     x_in,
    input  logic [TGT_W-1:0] tgt_in,
    input  logic             in_valid,
    output logic [TGT_W-1:0] tgt_out,
    output logic             out_valid,
    output logic             flip_out,
    output logic             armed,
    output logic [CNT_W-1:0] flip_cnt
);

    localparam int KW = 2 * N;
    localparam int BW = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(KW - 1);
    localparam logic LOCK_FE = (LOCKOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      key_q, key_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [TGT_W-1:0]   tgt_q, tgt_d;
    logic               out_valid_q, out_valid_d;
    logic               flip_q, flip_d;
    logic               armed_q, armed_d;
    logic [CNT_W-1:0]   flip_cnt_q, flip_cnt_d;

    logic [N-1:0]       k1, k2;
    logic               g, gb, f, fe;

    assign k1 = key_q[N-1:0];
    assign k2 = key_q[KW-1:N];

    // Anti-SAT flip term; it is only honoured while ARMED, otherwise the lockout value applies
    always_comb begin
        g  = &(x_in ^ k1);
        gb = ~&(x_in ^ k2);
        f  = g & gb;
        fe = (state_q == ARMED) ? f : LOCK_FE;
    end

    // Key loader: key_clear beats key_start, and key_start beats key_valid
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        bit_cnt_d = bit_cnt_q;
        if (key_clear) begin
            state_d   = IDLE;
            key_d     = '0;
            bit_cnt_d = '0;
        end else if (key_start) begin
            // Restart keeps old key bits until each one is overwritten
            state_d   = LOAD;
            bit_cnt_d = '0;
        end else if (state_q == LOAD && key_valid) begin
            key_d[bit_cnt_q] = key_bit;
            if (bit_cnt_q == LAST_BIT) begin
                state_d   = ARMED;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BW'(1);
            end
        end
    end

    // Output pipeline and flip-event counter; data registers hold when no input is valid
    always_comb begin
        tgt_d       = tgt_q;
        flip_d      = flip_q;
        out_valid_d = in_valid;
        flip_cnt_d  = flip_cnt_q;
        armed_d     = (state_d == ARMED);
        if (in_valid) begin
            tgt_d  = tgt_in ^ {TGT_W{fe}};
            flip_d = fe;
        end
        if (key_clear) begin
            flip_cnt_d = '0;
        end else if (in_valid && (state_q == ARMED) && f && (flip_cnt_q != {CNT_W{1'b1}})) begin
            flip_cnt_d = flip_cnt_q + CNT_W'(1);
        end
    end

    // State, key and output registers; an asynchronous reset zeroises any partial key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= '0;
            bit_cnt_q   <= '0;
            tgt_q       <= '0;
            out_valid_q <= 1'b0;
            flip_q      <= 1'b0;
            armed_q     <= 1'b0;
            flip_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            bit_cnt_q   <= bit_cnt_d;
            tgt_q       <= tgt_d;
            out_valid_q <= out_valid_d;
            flip_q      <= flip_d;
            armed_q     <= armed_d;
            flip_cnt_q  <= flip_cnt_d;
        end
    end

    assign tgt_out   = tgt_q;
    assign out_valid = out_valid_q;
    assign flip_out  = flip_q;
    assign armed     = armed_q;
    assign flip_cnt  = flip_cnt_q;

endmodule

// File: tb/tb_antisat_seq_lock.sv
// Randomised self-checking bench for antisat_seq_lock (N=4, TGT_W=2, CNT_W=3, LOCKOUT=1).
module tb_antisat_seq_lock;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_bit, key_valid, key_start, key_clear;
    logic [3:0] x_in;
    logic [1:0] tgt_in;
    logic       in_valid;
    logic [1:0] tgt_out;
    logic       out_valid, flip_out, armed;
    logic [2:0] flip_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_key;
    int         m_pos;
    bit         m_loading, m_armed;
    logic [1:0] m_tgt;
    logic       m_flip, m_ov;
    int         m_cnt;

    antisat_seq_lock #(.N(4), .TGT_W(2), .CNT_W(3), .LOCKOUT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_bit(key_bit), .key_valid(key_valid), .key_start(key_start), .key_clear(key_clear),
        .x_in(x_in), .tgt_in(tgt_in), .in_valid(in_valid),
        .tgt_out(tgt_out), .out_valid(out_valid), .flip_out(flip_out),
        .armed(armed), .flip_cnt(flip_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_key = '0; m_pos = 0; m_loading = 0; m_armed = 0;
        m_tgt = '0; m_flip = 0; m_ov = 0; m_cnt = 0;
    endtask

    // Wrong key flips on exactly one input value: x == ~K1 with K1 != K2
    function automatic bit model_f(input logic [3:0] x);
        logic [3:0] k1, k2;
        k1 = m_key[3:0];
        k2 = m_key[7:4];
        return (x == ~k1) && (k1 != k2);
    endfunction

    task automatic model_step(input logic kb, input logic kv, input logic ks, input logic kc,
                              input logic [3:0] x, input logic [1:0] t, input logic iv);
        bit fe, f;
        f  = model_f(x);
        fe = m_armed ? f : 1'b1;
        m_ov = iv;
        if (iv) begin
            m_tgt  = fe ? ~t : t;
            m_flip = fe;
        end
        if (kc) m_cnt = 0;
        else if (iv && m_armed && f && m_cnt < 7) m_cnt++;
        if (kc) begin
            m_key = '0; m_pos = 0; m_loading = 0; m_armed = 0;
        end else if (ks) begin
            m_loading = 1; m_armed = 0; m_pos = 0;
        end else if (m_loading && kv) begin
            m_key[m_pos] = kb;
            m_pos++;
            if (m_pos == 8) begin
                m_loading = 0; m_armed = 1; m_pos = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".tgt_out"},   32'(tgt_out),   32'(m_tgt));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".flip_out"},  32'(flip_out),  32'(m_flip));
        check({tag, ".armed"},     32'(armed),     32'(m_armed));
        check({tag, ".flip_cnt"},  32'(flip_cnt),  32'(m_cnt));
    endtask

    // One clock of stimulus: drive, clock, update model, sample 1 time unit after the edge
    task automatic step(input string tag, input logic kb, input logic kv, input logic ks, input logic kc,
                        input logic [3:0] x, input logic [1:0] t, input logic iv);
        key_bit = kb; key_valid = kv; key_start = ks; key_clear = kc;
        x_in = x; tgt_in = t; in_valid = iv;
        @(posedge clk);
        model_step(kb, kv, ks, kc, x, t, iv);
        #1;
        compare_all(tag);
        $display("%s: x=%h tgt_in=%h iv=%b ks=%b kv=%b kc=%b -> tgt_out=%h ov=%b flip=%b armed=%b cnt=%0d",
                 tag, x, t, iv, ks, kv, kc, tgt_out, out_valid, flip_out, armed, flip_cnt);
    endtask

    task automatic idle_data(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom), 2'($urandom), 1'($urandom));
    endtask

    // key_start, then 8 key bits with random gaps and random data traffic alongside
    task automatic load_key(input string tag, input logic [3:0] k1, input logic [3:0] k2);
        logic [7:0] kv_bits;
        kv_bits = {k2, k1};
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 4'($urandom), 2'($urandom), 1'($urandom));
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) == 0) idle_data(tag);
            step(tag, kv_bits[i], 1'b1, 1'b0, 1'b0, 4'($urandom), 2'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        logic [3:0] rk1, rk2, rx;
        rst_n = 1'b0;
        key_bit = 0; key_valid = 0; key_start = 0; key_clear = 0;
        x_in = '0; tgt_in = '0; in_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        compare_all("reset");

        // Lockout with no key loaded
        step("lockout", 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 2'b01, 1'b1);
        check("lockout.direct_tgt", 32'(tgt_out), 32'h2);
        check("lockout.direct_armed", 32'(armed), 32'h0);

        // Correct key: armed rises right after the 8th bit, then no corruption
        load_key("load_ok", 4'b1010, 4'b1010);
        check("load_ok.armed", 32'(armed), 32'h1);
        for (int i = 0; i < 16; i++) step("sweep_ok", 1'b0, 1'b0, 1'b0, 1'b0, 4'(i), 2'b11, 1'b1);
        check("sweep_ok.cnt", 32'(flip_cnt), 32'h0);

        // Wrong key: flips only for x_in = ~K1 = 0101
        step("clear", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0);
        load_key("load_bad", 4'b1010, 4'b0011);
        for (int i = 0; i < 16; i++) begin
            step("sweep_bad", 1'b0, 1'b0, 1'b0, 1'b0, 4'(i), 2'b11, 1'b1);
            check("sweep_bad.flip", 32'(flip_out), (i == 5) ? 32'h1 : 32'h0);
        end
        check("sweep_bad.cnt", 32'(flip_cnt), 32'h1);

        // Counter saturation at 7
        step("clear", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0);
        load_key("load_sat", 4'b1010, 4'b0011);
        for (int i = 0; i < 10; i++) begin
            step("sat", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 2'($urandom), 1'b1);
            check("sat.cnt", 32'(flip_cnt), (i < 7) ? 32'(i + 1) : 32'h7);
        end

        // key_clear beats key_valid in LOAD after 3 bits
        step("prio", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) step("prio", 1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom), 2'($urandom), 1'b1);
        step("prio_clr", 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 2'b01, 1'b1);
        check("prio.cnt", 32'(flip_cnt), 32'h0);
        check("prio.armed", 32'(armed), 32'h0);

        // Asynchronous reset in the middle of a load
        step("abort", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b01, 1'b1);
        step("abort", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'b01, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check("async_rst.tgt_direct", 32'(tgt_out), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        compare_all("post_rst");

        // Reload from ARMED follows lockout until the new key completes
        load_key("reload", 4'b0110, 4'b0110);
        check("reload.armed1", 32'(armed), 32'h1);
        step("reload_start", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b00, 1'b1);
        check("reload.armed0", 32'(armed), 32'h0);
        step("reload_lock", 1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 2'b10, 1'b1);
        check("reload.lock_tgt", 32'(tgt_out), 32'h1);
        for (int i = 0; i < 8; i++) step("reload", 1'(i & 1), 1'b1, 1'b0, 1'b0, 4'($urandom), 2'($urandom), 1'b1);
        check("reload.armed2", 32'(armed), 32'h1);

        // Random rounds: random keys (half correct), biased x, occasional control pulses
        for (int r = 0; r < 12; r++) begin
            rk1 = 4'($urandom);
            rk2 = ($urandom_range(0, 1) == 0) ? rk1 : 4'($urandom);
            if ($urandom_range(0, 3) == 0) step("rnd_clr", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0);
            load_key("rnd_load", rk1, rk2);
            for (int c = 0; c < 30; c++) begin
                int sel;
                sel = int'($urandom_range(0, 99));
                rx = ($urandom_range(0, 2) == 0) ? ~m_key[3:0] : 4'($urandom);
                step("rnd", 1'($urandom), 1'($urandom), 1'(sel < 2), 1'(sel == 99),
                     rx, 2'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/antisat_seq_lock.md
Name: antisat_seq_lock

Overview:
- Parametrised, clocked successor to the flat 16-bit Anti-SAT key-compare used on combinational benchmarks.
- Holds a 2N-bit key in an internal serially loaded key register.
- Computes the Anti-SAT flip bit over an N-bit observed input vector.
- Corrupts TGT_W protected target bits through a one-stage registered XOR, and keeps a saturating count of flip events for the test harness.
- Sits between the benchmark's internal nets and its outputs. It is instantiated once per locked design by the obfuscation generator.

Parameters:
- N, 16, compare width: number of observed circuit inputs. Key halves K1 and K2 are N bits each.
- TGT_W, 1, number of protected internal nets XOR-corrupted by the flip bit.
- CNT_W, 16, width of the saturating flip-event counter.
- LOCKOUT, 1, 1: targets are inverted while not ARMED. 0: targets pass through unmodified while not ARMED.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_bit, input, 1, serial key data, LSB of K1 first. K1 occupies key positions 0..N-1 and K2 occupies N..2N-1.
- key_valid, input, 1, shifts key_bit in when high in LOAD.
- key_start, input, 1, begins a key load (IDLE or ARMED -> LOAD).
- key_clear, input, 1, zeroises the key and returns to IDLE.
- x_in, input, N, observed circuit inputs.
- tgt_in, input, TGT_W, unprotected target nets.
- in_valid, input, 1, x_in and tgt_in are valid this cycle.
- tgt_out, output, TGT_W, protected target nets, registered.
- out_valid, output, 1, tgt_out is valid.
- flip_out, output, 1, registered flip bit applied to tgt_out.
- armed, output, 1, high in the ARMED state.
- flip_cnt, output, CNT_W, saturating count of cycles with in_valid and flip both set while ARMED.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; key register = 0; bit counter = 0.
  - tgt_out = 0, out_valid = 0, flip_out = 0, armed = 0, flip_cnt = 0.
- States: IDLE, LOAD, ARMED.
- IDLE:
  - key_start -> LOAD, and the bit counter is cleared.
  - key_valid is ignored.
- LOAD:
  - Each cycle with key_valid high writes key_bit into key position bit_cnt, then bit_cnt increments.
  - When the bit with bit_cnt = 2N-1 is accepted, the next state is ARMED.
  - key_start in LOAD restarts the load: bit_cnt = 0, previously written bits are retained until overwritten.
- ARMED:
  - The key is frozen.
  - key_start -> LOAD, which starts a full reload.
- key_clear in any state:
  - Next state IDLE, key = 0, bit_cnt = 0.
  - key_clear has priority over key_start and key_valid in the same cycle.
- Flip function (combinational on the registered key):
  - g = AND-reduce(x_in ^ K1).
  - gb = NAND-reduce(x_in ^ K2).
  - f = g & gb.
- Effective flip fe:
  - ARMED: fe = f.
  - Otherwise: fe = LOCKOUT.
- Output pipeline, 1-cycle latency. On every rising edge:
  - out_valid <= in_valid.
  - If in_valid: tgt_out <= tgt_in ^ {TGT_W{fe}} and flip_out <= fe.
  - Otherwise tgt_out and flip_out hold their values.
- flip_cnt:
  - Increments on a cycle with in_valid && ARMED && f.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset or key_clear.
- Correct key (K1 == K2):
  - g & gb = 1 only when x_in == ~K1 and x_in != ~K2, which is impossible, so f is always 0.
  - tgt_out equals tgt_in delayed by one cycle.
- Wrong key (K1 != K2): f = 1 for exactly one x_in value, x_in = ~K1.
- State change in the same cycle as in_valid: fe uses the state before the clock edge. The ARMED transition affects data from the next cycle onward.
- Reset mid-LOAD: the partial key is discarded (zeroised).
- armed is a registered decode of state and has no combinational path from the inputs.

Test Plan:
- Reset and lockout: N=4, TGT_W=2, LOCKOUT=1. Release reset, then apply in_valid=1, tgt_in=2'b01 with no key loaded -> next cycle tgt_out=2'b10, flip_out=1, out_valid=1, armed=0, flip_cnt=0.
- Correct key load: N=4. Pulse key_start, then send 8 bits for K1=K2=4'b1010 -> armed rises one cycle after the 8th key_valid. Sweep x_in over all 16 values with tgt_in=2'b11 -> tgt_out=2'b11 every cycle, flip_cnt=0.
- Wrong key: K1=4'b1010, K2=4'b0011, sweep x_in 0..15 -> flip_out=1 only for x_in=4'b0101 (tgt_out=2'b00 when tgt_in=2'b11); flip_cnt=1 after the sweep.
- Counter saturation: CNT_W=3, wrong key, hold x_in=~K1 for 10 valid cycles -> flip_cnt reads 1..7, then stays at 7.
- Control priority and abort:
  - key_clear asserted together with key_valid in LOAD after 3 bits -> state IDLE, key=0, armed=0, flip_cnt=0.
  - rst_n low mid-LOAD -> all outputs are 0 immediately, without waiting for a clock edge.
- Reload from ARMED: ARMED with the correct key, pulse key_start -> armed=0 the next cycle and LOAD outputs follow LOCKOUT. Complete an 8-bit load -> armed=1 again.
